irq_sequencer: RTL and testbench
================================

// Module: irq_sequencer
// PURPOSE
//  Interrupt entry/exit sequencer for the 5-stage pipeline CPU. Latches edge-triggered requests (timer, UART RX, UART TX),
//  masks and prioritises them, and injects one interrupt into ID only at a safe point. A safe point has no jump in ID,
//  no taken branch in EX, no load-use stall and no supervisor PC. Tracks handler residency until ERET and enforces
//  a post-return cooldown so user code always makes forward progress.
// PARAMETERS
//  SRC_NUM     3   number of interrupt sources; index 0 = highest priority
//  CAUSE_W     2   width of irq_cause; must satisfy 2**CAUSE_W >= SRC_NUM
//  HOLD_THRESH 8   consecutive unsafe cycles in ARMED before irq_hold asserts
//  COOL_CYC    2   cycles spent in COOLDOWN after ERET; range 1..15
// PORTS
//  clk          in   1        pipeline clock
//  reset        in   1        synchronous, active-high
//  irq_src      in   SRC_NUM  raw level requests from peripherals
//  pc_super     in   1        IF PC bit 31 (supervisor mode)
//  id_jump      in   1        J- or JR-class instruction in ID
//  ex_branch_en in   1        branch taken in EX
//  loaduse      in   1        load-use stall active this cycle
//  eret_id      in   1        handler return (jr $26) decoded in ID
//  mask_we      in   1        mask write strobe
//  mask_wdata   in   SRC_NUM  new mask value; 1 = enabled
//  irq_take     out  1        one-cycle pulse: ID injects the interrupt and saves the return PC to $26
//  irq_cause    out  CAUSE_W  index of the source taken; valid while irq_take=1, held until the next take
//  irq_hold     out  1        freezes IF fetch so that the pipeline drains
//  irq_pending  out  SRC_NUM  latched pending bits
//  irq_mask     out  SRC_NUM  current mask
//  in_handler   out  1        1 from TAKE until ERET
// BEHAVIOUR
//  Reset values
//   - All outputs 0 except irq_mask, which resets to all-ones. State resets to IDLE; all counters reset to 0.
//  Pending latch
//   - pend[i] sets on a 0->1 edge of irq_src[i], detected against a registered copy of irq_src.
//   - pend[i] clears in the cycle where irq_take=1 and irq_cause=i.
//   - A new edge in that same cycle wins: the bit stays 1.
//  Mask
//   - mask_we updates irq_mask on the next edge.
//   - Any state that reads the mask sees the new value one cycle after the write.
//  Selection
//   - sel = lowest index i with pend[i] & mask[i].
//   - avail = |(pend & mask).
//  Safe point
//   - safe = !id_jump & !ex_branch_en & !loaduse & !pc_super.
//  State machine
//   - IDLE:     avail -> ARMED.
//   - ARMED:    !avail (masked or cleared) -> IDLE, with no take.
//               else if safe -> TAKE.
//               else unsafe_cnt++ (saturating). When unsafe_cnt >= HOLD_THRESH, irq_hold=1, registered, and stays 1 until TAKE.
//   - TAKE:     exactly 1 cycle. irq_take=1, irq_cause=sel latched on ARMED->TAKE, in_handler becomes 1 on the same edge.
//               Then -> HANDLER. unsafe_cnt and irq_hold clear.
//   - HANDLER:  in_handler=1. New edges still latch into pend but are not taken. eret_id -> COOLDOWN.
//   - COOLDOWN: in_handler=0. Counts COOL_CYC cycles, then -> IDLE. No take is possible in this state.
//  Latency
//   - Source edge at cycle n, masked-on, pipeline safe: ARMED at n+2, irq_take at n+3.
//  Boundary conditions
//   - ex_branch_en takes precedence: no TAKE while a branch flushes.
//   - eret_id outside HANDLER is ignored.
//   - mask_we with mask_wdata=0 while in ARMED -> IDLE on the following cycle.
//   - Reset asserted mid-HANDLER returns to IDLE and clears pend and in_handler.
// STRUCTURE
//  - Shared package pipeline_pkg holds:
//      - the state encoding: IDLE=0, ARMED=1, TAKE=2, HANDLER=3, COOLDOWN=4, in a 3-bit localparam set;
//      - the cause codes: TIMER=0, UART_RX=1, UART_TX=2;
//      - the return-address register index Xp=26.
//  - One sub-module, irq_edge_latch, instanced once per source: edge detect plus the pend bit with set-wins-over-clear.
//  - Top level holds the FSM, the priority encoder, unsafe_cnt and cool_cnt.
// TESTING
//  1. Reset, then pulse irq_src=3'b001 with safe=1 -> irq_take at +3 cycles, irq_cause=0, in_handler=1, pend=0.
//  2. irq_src=3'b110 edges together, mask=3'b111 -> cause=1 taken first.
//     After eret_id and COOL_CYC=2, cause=2 is taken.
//  3. Edge on src0 with ex_branch_en held high for 10 cycles -> no take; irq_hold=1 after 8 unsafe cycles;
//     irq_take the cycle after branch_en drops; irq_hold then returns to 0.
//  4. Source pending in ARMED, mask_we with mask_wdata=0 -> back to IDLE, no take, pend stays 1.
//     Restoring the mask -> take follows.
//  5. New src0 edge in the TAKE cycle -> pend[0] remains 1. Re-take occurs only after ERET plus cooldown.
//  6. Assert reset during HANDLER -> the next cycle shows all outputs 0, irq_mask=all-ones, state IDLE.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions used by the interrupt sequencer.
//   - interrupt sequencer state encoding (3-bit) and its enum type
//   - interrupt cause codes (source index == cause code)
//   - index of the register that receives the interrupt return PC
package pipeline_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ARMED    = 3'd1;
  localparam logic [2:0] ST_TAKE     = 3'd2;
  localparam logic [2:0] ST_HANDLER  = 3'd3;
  localparam logic [2:0] ST_COOLDOWN = 3'd4;

  typedef enum logic [2:0] {
    IDLE     = ST_IDLE,
    ARMED    = ST_ARMED,
    TAKE     = ST_TAKE,
    HANDLER  = ST_HANDLER,
    COOLDOWN = ST_COOLDOWN
  } irq_state_t;

  // Cause codes; a lower code is a higher priority.
  localparam int TIMER   = 0;
  localparam int UART_RX = 1;
  localparam int UART_TX = 2;

  // Return PC of an interrupt is written to $26.
  localparam int XP = 26;

endpackage

// File: rtl/irq_sequencer_if.sv
// Signal bundle between the pipeline and the interrupt sequencer.
//   slave  : the sequencer side (pipeline status in, interrupt control out)
//   master : the pipeline / peripheral side
// Handshake: irq_take is a single-cycle strobe with no back-pressure. The
// consumer (ID stage) must inject the interrupt in exactly the cycle
// irq_take=1; irq_cause is valid in that cycle and held until the next take.
// dbg_state exposes the sequencer FSM state for observation.
interface irq_sequencer_if #(
  parameter int SRC_NUM = 3,
  parameter int CAUSE_W = 2
);
  logic [SRC_NUM-1:0] irq_src;
  logic               pc_super;
  logic               id_jump;
  logic               ex_branch_en;
  logic               loaduse;
  logic               eret_id;
  logic               mask_we;
  logic [SRC_NUM-1:0] mask_wdata;
  logic               irq_take;
  logic [CAUSE_W-1:0] irq_cause;
  logic               irq_hold;
  logic [SRC_NUM-1:0] irq_pending;
  logic [SRC_NUM-1:0] irq_mask;
  logic               in_handler;
  logic [2:0]         dbg_state;

  modport slave (
    input  irq_src, pc_super, id_jump, ex_branch_en, loaduse, eret_id,
           mask_we, mask_wdata,
    output irq_take, irq_cause, irq_hold, irq_pending, irq_mask,
           in_handler, dbg_state
  );

  modport master (
    output irq_src, pc_super, id_jump, ex_branch_en, loaduse, eret_id,
           mask_we, mask_wdata,
    input  irq_take, irq_cause, irq_hold, irq_pending, irq_mask,
           in_handler, dbg_state
  );
endinterface

// File: rtl/irq_edge_latch.sv
// Edge detector and pending bit for one interrupt source.
//   clk, reset : pipeline clock, synchronous active-high reset
//   src        : raw level request from the peripheral
//   clr        : the sequencer consumed this source this cycle
//   pend       : latched pending bit
// A rising edge seen in the same cycle as clr wins, so the bit stays set.
module irq_edge_latch (
  input  logic clk,
  input  logic reset,
  input  logic src,
  input  logic clr,
  output logic pend
);
  logic src_q;
  logic rise;

  assign rise = src & ~src_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      src_q <= 1'b0;
      pend  <= 1'b0;
    end else begin
      src_q <= src;
      pend  <= rise | (pend & ~clr);
    end
  end
endmodule

// File: rtl/irq_sequencer.sv
// Interrupt entry/exit sequencer for the 5-stage pipeline.
//   clk, reset : pipeline clock, synchronous active-high reset
//   bus        : irq_sequencer_if.slave
//     in : irq_src, pc_super, id_jump, ex_branch_en, loaduse, eret_id,
//          mask_we, mask_wdata
//     out: irq_take, irq_cause, irq_hold, irq_pending, irq_mask,
//          in_handler, dbg_state
// Latches request edges, masks and prioritises them (index 0 highest),
// injects one interrupt only when the pipeline is at a safe point, tracks
// handler residency until ERET and then enforces a short cooldown.
module irq_sequencer
  import pipeline_pkg::*;
#(
  parameter int SRC_NUM     = 3,
  parameter int CAUSE_W     = 2,
  parameter int HOLD_THRESH = 8,
  parameter int COOL_CYC    = 2
) (
  input logic            clk,
  input logic            reset,
  irq_sequencer_if.slave bus
);
  localparam int UW = $clog2(HOLD_THRESH + 1);

  irq_state_t         state, state_n;
  logic [SRC_NUM-1:0] pend;
  logic [SRC_NUM-1:0] mask_q;
  logic [SRC_NUM-1:0] req;
  logic [SRC_NUM-1:0] take_clr;
  logic [CAUSE_W-1:0] sel;
  logic [CAUSE_W-1:0] cause_q;
  logic               avail;
  logic               safe;
  logic               go_take;
  logic [UW-1:0]      unsafe_cnt;
  logic [UW-1:0]      unsafe_nx;
  logic               hold_q;
  logic               in_handler_q;
  logic [3:0]         cool_cnt;

  // Pending latches, one per source.
  for (genvar i = 0; i < SRC_NUM; i++) begin : g_src
    irq_edge_latch u_latch (
      .clk   (clk),
      .reset (reset),
      .src   (bus.irq_src[i]),
      .clr   (take_clr[i]),
      .pend  (pend[i])
    );
  end

  // Priority encoder: lowest enabled pending index wins.
  always_comb begin
    req = pend & mask_q;
    sel = '0;
    for (int i = SRC_NUM - 1; i >= 0; i--) begin
      if (req[i]) sel = CAUSE_W'(i);
    end
    avail = |req;
  end

  // A branch flush, jump in ID, load-use stall or supervisor PC all make
  // the return PC ambiguous, so injection waits.
  assign safe    = ~bus.id_jump & ~bus.ex_branch_en & ~bus.loaduse & ~bus.pc_super;
  assign go_take = (state == ARMED) && avail && safe;

  always_comb begin
    for (int i = 0; i < SRC_NUM; i++) begin
      take_clr[i] = (state == TAKE) && (cause_q == CAUSE_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (avail) state_n = ARMED;
      ARMED: begin
        if (!avail)    state_n = IDLE;
        else if (safe) state_n = TAKE;
      end
      TAKE:     state_n = HANDLER;
      HANDLER:  if (bus.eret_id) state_n = COOLDOWN;
      COOLDOWN: if (cool_cnt == 4'(COOL_CYC - 1)) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  assign unsafe_nx = (unsafe_cnt == UW'(HOLD_THRESH)) ? unsafe_cnt : unsafe_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q       <= '1;
      cause_q      <= '0;
      unsafe_cnt   <= '0;
      hold_q       <= 1'b0;
      in_handler_q <= 1'b0;
      cool_cnt     <= '0;
    end else begin
      if (bus.mask_we) mask_q <= bus.mask_wdata;

      // Hold and its counter persist until an interrupt is actually taken.
      if (go_take) begin
        cause_q    <= sel;
        unsafe_cnt <= '0;
        hold_q     <= 1'b0;
      end else if (state == ARMED && avail) begin
        unsafe_cnt <= unsafe_nx;
        if (unsafe_nx >= UW'(HOLD_THRESH)) hold_q <= 1'b1;
      end

      if (go_take)                             in_handler_q <= 1'b1;
      else if (state == HANDLER && bus.eret_id) in_handler_q <= 1'b0;

      if (state == COOLDOWN) cool_cnt <= cool_cnt + 1'b1;
      else                   cool_cnt <= '0;
    end
  end

  assign bus.irq_take    = (state == TAKE);
  assign bus.irq_cause   = cause_q;
  assign bus.irq_hold    = hold_q;
  assign bus.irq_pending = pend;
  assign bus.irq_mask    = mask_q;
  assign bus.in_handler  = in_handler_q;
  assign bus.dbg_state   = state;
endmodule

// File: tb/tb_irq_sequencer.sv
// Directed bench for irq_sequencer with a rule-level reference model.
module tb_irq_sequencer;
  localparam int HOLD_THRESH = 8;
  localparam int COOL_CYC    = 2;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_err    = 0;
  bit   chk_en   = 0;

  irq_sequencer_if #(.SRC_NUM(3), .CAUSE_W(2)) bus ();

  irq_sequencer #(
    .SRC_NUM(3), .CAUSE_W(2), .HOLD_THRESH(HOLD_THRESH), .COOL_CYC(COOL_CYC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checker ----------------
  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Phase flags instead of a state code: armed, take strobe, handler
  // residency, remaining cooldown cycles. None set means idle.
  logic [2:0] m_pend, m_mask, m_prev;
  bit         m_take, m_inh, m_armed, m_hold;
  int         m_cool, m_unsafe, m_cause;

  function automatic int lowest(input logic [2:0] v);
    for (int i = 0; i < 3; i++) if (v[i]) return i;
    return 0;
  endfunction

  always @(posedge clk) begin
    logic [2:0] req;
    logic [2:0] clr;
    bit         safe;
    int         nu;
    if (reset) begin
      m_pend <= '0; m_mask <= '1; m_prev <= '0;
      m_take <= 0; m_inh <= 0; m_armed <= 0; m_hold <= 0;
      m_cool <= 0; m_unsafe <= 0; m_cause <= 0;
    end else begin
      req  = m_pend & m_mask;
      clr  = m_take ? 3'(1 << m_cause) : 3'b000;
      safe = !bus.id_jump && !bus.ex_branch_en && !bus.loaduse && !bus.pc_super;
      m_prev <= bus.irq_src;
      m_mask <= bus.mask_we ? bus.mask_wdata : m_mask;
      m_pend <= (m_pend & ~clr) | (bus.irq_src & ~m_prev);
      m_take <= 0;
      if (m_take) begin
        m_inh <= 1;
      end else if (m_inh) begin
        if (bus.eret_id) begin
          m_inh  <= 0;
          m_cool <= COOL_CYC;
        end
      end else if (m_cool > 0) begin
        m_cool <= m_cool - 1;
      end else if (m_armed) begin
        if (req == 0) begin
          m_armed <= 0;
        end else if (safe) begin
          m_armed  <= 0;
          m_take   <= 1;
          m_inh    <= 1;
          m_cause  <= lowest(req);
          m_unsafe <= 0;
          m_hold   <= 0;
        end else begin
          nu = (m_unsafe < HOLD_THRESH) ? m_unsafe + 1 : m_unsafe;
          m_unsafe <= nu;
          if (nu >= HOLD_THRESH) m_hold <= 1;
        end
      end else if (req != 0) begin
        m_armed <= 1;
      end
    end
  end

  // Scoreboard compare every cycle once out of the initial reset.
  always @(negedge clk) begin
    if (chk_en) begin
      check("take",       int'(bus.irq_take),    int'(m_take));
      check("cause",      int'(bus.irq_cause),   m_cause);
      check("hold",       int'(bus.irq_hold),    int'(m_hold));
      check("pending",    int'(bus.irq_pending), int'(m_pend));
      check("mask",       int'(bus.irq_mask),    int'(m_mask));
      check("in_handler", int'(bus.in_handler),  int'(m_inh));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic eret_pulse();
    cyc(); bus.eret_id = 1'b1;
    cyc(); bus.eret_id = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_take"},  int'(bus.irq_take),    0);
    check({tag, "_cause"}, int'(bus.irq_cause),   0);
    check({tag, "_hold"},  int'(bus.irq_hold),    0);
    check({tag, "_pend"},  int'(bus.irq_pending), 0);
    check({tag, "_mask"},  int'(bus.irq_mask),    7);
    check({tag, "_inh"},   int'(bus.in_handler),  0);
    check({tag, "_state"}, int'(bus.dbg_state),   0);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1'b1;
    bus.irq_src = '0; bus.pc_super = 0; bus.id_jump = 0; bus.ex_branch_en = 0;
    bus.loaduse = 0; bus.eret_id = 0; bus.mask_we = 0; bus.mask_wdata = '0;
    cyc(); cyc();
    @(negedge clk); check_reset_state("rst");
    cyc(); reset = 1'b0; chk_en = 1;

    // 1: single timer edge, safe pipeline -> take three cycles later
    cyc(); bus.irq_src = 3'b001;
    cyc(); bus.irq_src = 3'b000;
    cyc(); @(negedge clk); check("t1_armed", int'(bus.dbg_state), 1);
    cyc(); @(negedge clk);
    check("t1_take", int'(bus.irq_take), 1);
    check("t1_cause", int'(bus.irq_cause), 0);
    check("t1_inh", int'(bus.in_handler), 1);
    cyc(); @(negedge clk);
    check("t1_pend", int'(bus.irq_pending), 0);
    eret_pulse(); run(4);

    // 2: two simultaneous edges, priority then re-take after cooldown
    cyc(); bus.irq_src = 3'b110;
    cyc(); bus.irq_src = 3'b000;
    cyc();
    cyc(); @(negedge clk);
    check("t2_take1", int'(bus.irq_take), 1);
    check("t2_cause1", int'(bus.irq_cause), 1);
    cyc();
    cyc(); bus.eret_id = 1'b1;
    cyc(); bus.eret_id = 1'b0;
    cyc(); @(negedge clk);
    check("t2_cool_take", int'(bus.irq_take), 0);
    check("t2_cool_inh", int'(bus.in_handler), 0);
    cyc(); cyc();
    cyc(); @(negedge clk);
    check("t2_take2", int'(bus.irq_take), 1);
    check("t2_cause2", int'(bus.irq_cause), 2);
    eret_pulse(); run(4);

    // 3: branch flush holds off the take, hold asserts after 8 unsafe cycles
    cyc(); bus.irq_src = 3'b001; bus.ex_branch_en = 1'b1;
    cyc(); bus.irq_src = 3'b000;
    run(7);
    cyc(); @(negedge clk);
    check("t3_hold_early", int'(bus.irq_hold), 0);
    cyc(); bus.ex_branch_en = 1'b0; @(negedge clk);
    check("t3_hold", int'(bus.irq_hold), 1);
    check("t3_no_take", int'(bus.irq_take), 0);
    cyc(); @(negedge clk);
    check("t3_take", int'(bus.irq_take), 1);
    check("t3_hold_clr", int'(bus.irq_hold), 0);
    eret_pulse(); run(4);

    // 4: mask cleared while armed -> idle with pend kept; unmask -> take
    cyc(); bus.irq_src = 3'b001; bus.loaduse = 1'b1;
    cyc(); bus.irq_src = 3'b000;
    cyc(); bus.mask_we = 1'b1; bus.mask_wdata = 3'b000;
    cyc(); bus.mask_we = 1'b0; @(negedge clk);
    check("t4_mask", int'(bus.irq_mask), 0);
    cyc(); bus.loaduse = 1'b0; @(negedge clk);
    check("t4_idle", int'(bus.dbg_state), 0);
    check("t4_pend", int'(bus.irq_pending), 1);
    run(3);
    cyc(); bus.mask_we = 1'b1; bus.mask_wdata = 3'b111;
    cyc(); bus.mask_we = 1'b0;
    cyc();
    cyc(); @(negedge clk);
    check("t4_take", int'(bus.irq_take), 1);
    check("t4_cause", int'(bus.irq_cause), 0);
    eret_pulse(); run(4);

    // 5: new edge during the take cycle keeps pend[0]; re-take after cooldown
    cyc(); bus.irq_src = 3'b001;
    cyc(); bus.irq_src = 3'b000;
    cyc();
    cyc(); bus.irq_src = 3'b001; @(negedge clk);
    check("t5_take", int'(bus.irq_take), 1);
    cyc(); bus.irq_src = 3'b000; @(negedge clk);
    check("t5_pend_kept", int'(bus.irq_pending), 1);
    check("t5_inh", int'(bus.in_handler), 1);
    run(3);
    cyc(); bus.eret_id = 1'b1;
    cyc(); bus.eret_id = 1'b0;
    cyc(); @(negedge clk);
    check("t5_cool_take", int'(bus.irq_take), 0);
    cyc(); cyc();
    cyc(); @(negedge clk);
    check("t5_retake", int'(bus.irq_take), 1);
    check("t5_recause", int'(bus.irq_cause), 0);
    cyc(); @(negedge clk);
    check("t5_pend_clr", int'(bus.irq_pending), 0);
    eret_pulse(); run(4);

    // 6: reset in the middle of a handler
    cyc(); bus.irq_src = 3'b010;
    cyc(); bus.irq_src = 3'b000;
    cyc();
    cyc(); @(negedge clk);
    check("t6_take", int'(bus.irq_take), 1);
    check("t6_cause", int'(bus.irq_cause), 1);
    cyc(); bus.mask_we = 1'b1; bus.mask_wdata = 3'b011; bus.irq_src = 3'b100;
    cyc(); bus.mask_we = 1'b0; bus.irq_src = 3'b000; @(negedge clk);
    check("t6_mask", int'(bus.irq_mask), 3);
    check("t6_pend", int'(bus.irq_pending), 4);
    check("t6_inh", int'(bus.in_handler), 1);
    cyc(); reset = 1'b1;
    cyc(); reset = 1'b0; @(negedge clk);
    check_reset_state("t6_rst");
    run(3);

    // eret outside the handler has no effect
    cyc(); bus.eret_id = 1'b1;
    cyc(); bus.eret_id = 1'b0; @(negedge clk);
    check("eret_idle_state", int'(bus.dbg_state), 0);
    run(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
